// File: rtl/piso_tx_8bit.sv
// 8-bit parallel-in serial-out UART-style transmitter: start, 8 data bits LSB first, stop.
// Optional even-parity bit between data and stop when PIPO_PARITY_EN is defined.
module piso_tx_8bit #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PIPO_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_next;
    logic               tx_next;
    logic               busy_next;
    logic               done_next;
    logic               bit_tick;

`ifdef PIPO_PARITY_EN
    logic               par_q;
    logic               par_next;
`endif

    // Last cycle of the current bit period.
    assign bit_tick = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick && (idx_q == IDX_LAST)) begin
`ifdef PIPO_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef PIPO_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Next datapath values; outputs are derived from the next state so they
    // appear in the same cycle the state is entered.
    always_comb begin
        shift_next = shift_q;
        cnt_next   = '0;
        idx_next   = idx_q;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        done_next  = 1'b0;
`ifdef PIPO_PARITY_EN
        par_next   = par_q;
`endif

        if (state == S_IDLE) begin
            if (load) begin
                shift_next = data_in;
                idx_next   = '0;
`ifdef PIPO_PARITY_EN
                par_next   = ^data_in;
`endif
            end
        end else if (!bit_tick) begin
            cnt_next = cnt_q + CNT_W'(1);
        end

        if ((state == S_DATA) && bit_tick) begin
            shift_next = {1'b0, shift_q[DATA_W-1:1]};
            idx_next   = idx_q + IDX_W'(1);
        end

        done_next = (state == S_STOP) && bit_tick;
        busy_next = (state_next != S_IDLE);

        case (state_next)
            S_IDLE:   tx_next = 1'b1;
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
`ifdef PIPO_PARITY_EN
            S_PARITY: tx_next = par_q;
`endif
            S_STOP:   tx_next = 1'b1;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PIPO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shift_q <= shift_next;
            cnt_q   <= cnt_next;
            idx_q   <= idx_next;
            tx_out  <= tx_next;
            busy    <= busy_next;
            done    <= done_next;
`ifdef PIPO_PARITY_EN
            par_q   <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx_8bit.sv
// Directed self-checking bench for piso_tx_8bit with CLKS_PER_BIT = 4.
module tb_piso_tx_8bit;

    localparam int CPB = 4;
`ifdef PIPO_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       load;
    logic [7:0] data_in;
    logic       tx_out;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par;   // hand-computed even parity of data
    } vec_t;

    vec_t vecs[6];

    piso_tx_8bit #(.CLKS_PER_BIT(CPB)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .data_in (data_in),
        .tx_out  (tx_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
        logic [7:0] dv;
        dv = d;
        if (k == 0) return 1'b0;
        if (k <= 8) return dv[3'(k - 1)];
        if ((k == 9) && (NBITS == 11)) return p;
        return 1'b1;
    endfunction

    // Drive load for one edge; returns in cycle 1 of the frame.
    task automatic start_load(input logic [7:0] d);
        load    = 1'b1;
        data_in = d;
        step();
        load    = 1'b0;
    endtask

    // Checks every cycle of a frame starting at cycle 1; ends in the done cycle.
    task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                               input int inj_cycle, input logic [7:0] inj_data);
        int cyc;
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                cyc = k * CPB + c + 1;
                check($sformatf("%s tx bit%0d c%0d", name, k, cyc), tx_out, exp_bit(d, p, k));
                check($sformatf("%s busy c%0d", name, cyc), busy, 1'b1);
                check($sformatf("%s done c%0d", name, cyc), done, 1'b0);
                if (cyc == inj_cycle) begin
                    load    = 1'b1;
                    data_in = inj_data;
                end else if (cyc == inj_cycle + 1) begin
                    load = 1'b0;
                end
                step();
            end
        end
        check($sformatf("%s done pulse", name), done, 1'b1);
        check($sformatf("%s busy at done", name), busy, 1'b0);
        check($sformatf("%s tx at done", name), tx_out, 1'b1);
    endtask

    task automatic check_idle(input string name);
        check($sformatf("%s tx", name), tx_out, 1'b1);
        check($sformatf("%s busy", name), busy, 1'b0);
        check($sformatf("%s done", name), done, 1'b0);
    endtask

    initial begin
        vecs[0] = '{name: "v55", data: 8'h55, par: 1'b0};
        vecs[1] = '{name: "v07", data: 8'h07, par: 1'b1};
        vecs[2] = '{name: "v01", data: 8'h01, par: 1'b1};
        vecs[3] = '{name: "v80", data: 8'h80, par: 1'b1};
        vecs[4] = '{name: "vA5", data: 8'hA5, par: 1'b0};
        vecs[5] = '{name: "v3C", data: 8'h3C, par: 1'b0};

        RST     = 1'b0;
        load    = 1'b0;
        data_in = 8'h00;
        step();
        step();
        check_idle("reset");

        // load during reset is dropped
        load    = 1'b1;
        data_in = 8'hC3;
        step();
        check_idle("load in reset");
        load = 1'b0;
        RST  = 1'b1;
        step();
        check_idle("after reset release");

        for (int i = 0; i < 6; i++) begin
            start_load(vecs[i].data);
            check_frame(vecs[i].name, vecs[i].data, vecs[i].par, -1, 8'h00);
            step();
            check_idle($sformatf("%s post", vecs[i].name));
        end

        // second load while busy is ignored, data_in change has no effect
        start_load(8'hFF);
        check_frame("ignFF", 8'hFF, 1'b0, 12, 8'h00);
        step();
        check_idle("ignFF post");

        // reset mid-frame aborts without done
        start_load(8'hAA);
        for (int c = 1; c < 18; c++) step();
        check("abort busy pre", busy, 1'b1);
        RST = 1'b0;
        step();
        check_idle("abort in reset");
        RST = 1'b1;
        for (int c = 0; c < NBITS * CPB; c++) begin
            check($sformatf("abort no done c%0d", c), done, 1'b0);
            check($sformatf("abort idle tx c%0d", c), tx_out, 1'b1);
            step();
        end
        start_load(8'h55);
        check_frame("rec55", 8'h55, 1'b0, -1, 8'h00);
        step();
        check_idle("rec55 post");

        // load held high: back-to-back frames
        load    = 1'b1;
        data_in = 8'hFF;
        step();
        data_in = 8'h00;
        check_frame("b2b1", 8'hFF, 1'b0, -1, 8'h00);
        step();
        load = 1'b0;
        check_frame("b2b2", 8'h00, 1'b0, -1, 8'h00);
        step();
        check_idle("b2b post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
